// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the decode hazard / bypass controller.
// Class codes, controller FSM states and the scoreboard entry.
package hazard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_EXT  = 2'd2,
        CLS_POP  = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Destination address is kept beside the entry because its width
    // is a parameter of the controller.
    typedef struct packed {
        logic vld;
        logic we;
        cls_e cls;
    } sb_ent_t;

    localparam sb_ent_t SB_BUBBLE = '{vld: 1'b0, we: 1'b0, cls: CLS_ALU};

    // Producers whose result only exists after the EX stage.
    function automatic logic cls_late(input cls_e c);
        return (c == CLS_LOAD) || (c == CLS_POP);
    endfunction

endpackage

// File: rtl/hazard_ctrl_byp_match.sv
// byp_match: youngest-producer priority encoder for one read port.
// Reports a hit, the stage it hit in, and whether that producer is late.
module byp_match
    import hazard_pkg::*;
#(
    parameter int  REG_AW  = 5,
    parameter int  NUM_FWD = 3,
    localparam int IW      = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1
) (
    input  logic                      rd_en_i,
    input  logic [REG_AW-1:0]         addr_i,
    input  logic [NUM_FWD-1:0]        s_vld_i,
    input  logic [NUM_FWD-1:0]        s_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] s_dst_i,
    input  logic                      s0_late_i,
    output logic                      hit_o,
    output logic [IW-1:0]             idx_o,
    output logic                      nrdy_o
);

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (rd_en_i && (addr_i != '0) && s_vld_i[k] && s_we_i[k] &&
                (s_dst_i[k*REG_AW +: REG_AW] == addr_i)) begin
                hit_o = 1'b1;
                idx_o = IW'(k);
            end
        end
        nrdy_o = hit_o && (idx_o == '0) && s0_late_i;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-side scoreboard, stall/kill, bypass selects, halt drain.
// Define HAZARD_CTRL_EXT_EN to enable the multi-cycle EXT class in EX.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int  REG_AW      = 5,
    parameter int  NUM_RD      = 2,
    parameter int  NUM_FWD     = 3,
    parameter int  EXT_LAT     = 3,
    parameter int  FLUSH_DEPTH = 2,
    localparam int SW          = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_vld,
    input  logic [NUM_RD-1:0]        issue_rd_en,
    input  logic [NUM_RD*REG_AW-1:0] issue_rd_addr,
    input  logic                     issue_we,
    input  logic [REG_AW-1:0]        issue_dst,
    input  logic [1:0]               issue_cls,
    input  logic                     issue_hlt,
    input  logic                     flow_change,
    input  logic                     cancel_ex,
    output logic                     issue_stall,
    output logic                     issue_kill,
    output logic [NUM_RD*SW-1:0]     byp_sel,
    output logic                     ext_busy,
    output logic                     halted
);

    localparam int IW = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;
    localparam int FW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam int EW = (EXT_LAT > 1) ? $clog2(EXT_LAT) : 1;

    sb_ent_t                  ent_q [NUM_FWD];
    sb_ent_t                  ent_d [NUM_FWD];
    logic [REG_AW-1:0]        dst_q [NUM_FWD];
    logic [REG_AW-1:0]        dst_d [NUM_FWD];
    sb_ent_t                  s0_eff;
    sb_ent_t                  iss;
    logic [NUM_FWD-1:0]       s_vld;
    logic [NUM_FWD-1:0]       s_we;
    logic [NUM_FWD*REG_AW-1:0] s_dst;
    logic [NUM_RD-1:0]        m_hit;
    logic [NUM_RD-1:0]        m_nrdy;
    logic [IW-1:0]            m_idx [NUM_RD];
    logic [EW-1:0]            ext_cnt_q;
    logic                     ext_act;
    logic [FW-1:0]            flush_cnt_q;
    logic [NUM_RD*SW-1:0]     byp_q;
    logic [NUM_RD*SW-1:0]     byp_d;
    state_e                   state_q;
    logic                     halted_q;
    logic                     kill;
    logic                     stall;
    logic                     accept;
    logic                     drained;

    // Flatten the scoreboard for the matchers; a cancelled EX write drops out.
    always_comb begin
        s0_eff    = ent_q[0];
        s0_eff.we = ent_q[0].we & ~cancel_ex;
        s_vld     = '0;
        s_we      = '0;
        s_dst     = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            s_vld[k] = ent_q[k].vld;
            s_we[k]  = (k == 0) ? s0_eff.we : ent_q[k].we;
            s_dst[k*REG_AW +: REG_AW] = dst_q[k];
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        byp_match #(
            .REG_AW (REG_AW),
            .NUM_FWD(NUM_FWD)
        ) u_match (
            .rd_en_i  (issue_rd_en[i]),
            .addr_i   (issue_rd_addr[i*REG_AW +: REG_AW]),
            .s_vld_i  (s_vld),
            .s_we_i   (s_we),
            .s_dst_i  (s_dst),
            .s0_late_i(cls_late(ent_q[0].cls)),
            .hit_o    (m_hit[i]),
            .idx_o    (m_idx[i]),
            .nrdy_o   (m_nrdy[i])
        );
    end

    assign ext_act = (ext_cnt_q != '0);

    // ID is held for every cycle EX is occupied, so nothing is accepted
    // while S[0] is frozen.
    assign kill    = issue_vld & ((flush_cnt_q != '0) | flow_change);
    assign stall   = issue_vld & ~kill &
                     ((|m_nrdy) | ext_act | (state_q == ST_DRAIN));
    assign accept  = issue_vld & ~stall & ~kill;
    assign drained = ~(|s_vld) & ~ext_act;

    // Entry for the instruction leaving ID; HLT never writes.
    always_comb begin
        iss.vld = accept;
        iss.we  = accept & issue_we & ~issue_hlt;
        iss.cls = cls_e'(issue_cls);
    end

    // Bypass select for the instruction entering EX next cycle.
    always_comb begin
        byp_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (accept && m_hit[i]) begin
                byp_d[i*SW +: SW] = SW'(m_idx[i]) + SW'(1);
            end
        end
    end

    // Scoreboard advance; an EXT op keeps S[0] and feeds S[1] a bubble.
    always_comb begin
        ent_d[0] = ext_act ? s0_eff : iss;
        dst_d[0] = ext_act ? dst_q[0] : issue_dst;
        for (int k = 1; k < NUM_FWD; k++) begin
            if (k == 1) begin
                ent_d[k] = ext_act ? SB_BUBBLE : s0_eff;
            end else begin
                ent_d[k] = ent_q[k-1];
            end
            dst_d[k] = dst_q[k-1];
        end
    end

    // Scoreboard, bypass and flush registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                ent_q[k] <= SB_BUBBLE;
                dst_q[k] <= '0;
            end
            byp_q       <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_FWD; k++) begin
                ent_q[k] <= ent_d[k];
                dst_q[k] <= dst_d[k];
            end
            byp_q <= byp_d;
            if (flow_change) begin
                flush_cnt_q <= FW'(FLUSH_DEPTH - 1);
            end else if (flush_cnt_q != '0) begin
                flush_cnt_q <= flush_cnt_q - FW'(1);
            end
        end
    end

`ifdef HAZARD_CTRL_EXT_EN
    // EX occupancy countdown started by an accepted EXT op.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_cnt_q <= '0;
        end else if (accept && (issue_cls == CLS_EXT)) begin
            ext_cnt_q <= EW'(EXT_LAT - 1);
        end else if (ext_act) begin
            ext_cnt_q <= ext_cnt_q - EW'(1);
        end
    end
`else
    assign ext_cnt_q = '0;
`endif

    // Halt sequencing: drain in-flight work after HLT, then stay halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (accept && issue_hlt) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign issue_stall = stall;
    assign issue_kill  = kill;
    assign byp_sel     = byp_q;
    assign ext_busy    = ext_act;
    assign halted      = halted_q;

endmodule
